// File: rtl/eval_pkg.sv
// Shared types for the evaluation-stack arbiter: FSM states and the pending-slot record.
package eval_pkg;

  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              push;
    logic [DW_DEF-1:0] data;
  } slot_t;

endpackage

// File: rtl/evalstack_arbiter_if.sv
// Requester-side and stack-side signals of the evaluation-stack arbiter.
interface evalstack_arbiter_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  logic               r0_trigger;
  logic               r0_push;
  logic [DW-1:0]      r0_write;
  logic               r0_lock;
  logic [DW-1:0]      r0_read;
  logic               r0_done;
  logic               r1_trigger;
  logic               r1_push;
  logic [DW-1:0]      r1_write;
  logic               r1_lock;
  logic [DW-1:0]      r1_read;
  logic               r1_done;
  logic               evaltrigger;
  logic               evalpush;
  logic [DW-1:0]      evalwrite;
  logic [DW-1:0]      evalread;
  logic               evaldone;
  logic [DEPTH_W-1:0] depth;
  logic               err_ovf;
  logic               err_unf;

  // Arbiter side
  modport slave (
    input  r0_trigger, r0_push, r0_write, r0_lock,
    input  r1_trigger, r1_push, r1_write, r1_lock,
    input  evalread, evaldone,
    output r0_read, r0_done, r1_read, r1_done,
    output evaltrigger, evalpush, evalwrite, depth, err_ovf, err_unf
  );

  // Environment side (requesters plus stack)
  modport master (
    output r0_trigger, r0_push, r0_write, r0_lock,
    output r1_trigger, r1_push, r1_write, r1_lock,
    output evalread, evaldone,
    input  r0_read, r0_done, r1_read, r1_done,
    input  evaltrigger, evalpush, evalwrite, depth, err_ovf, err_unf
  );

endinterface

// File: rtl/eval_req_slot.sv
// Per-requester capture register: holds one trigger until the arbiter retires it.
module eval_req_slot
  import eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_trigger,
  input  logic              i_push,
  input  logic [DW_DEF-1:0] i_data,
  input  logic              i_clear,
  output slot_t             o_pend
);

  slot_t r_slot;

  // Load on trigger when empty; a trigger while full is ignored; clear wins over load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot.valid <= 1'b0;
    end else if (i_trigger && !r_slot.valid) begin
      r_slot.valid <= 1'b1;
      r_slot.push  <= i_push;
      r_slot.data  <= i_data;
    end
  end

  // Bypass an empty slot so a fresh trigger can be issued in its own cycle
  always_comb begin
    o_pend = r_slot;
    if (!r_slot.valid) begin
      o_pend.valid = i_trigger;
      o_pend.push  = i_push;
      o_pend.data  = i_data;
    end
  end

endmodule

// File: rtl/evalstack_arbiter.sv
// Two-requester round-robin arbiter for the evaluation-stack port with depth guarding.
module evalstack_arbiter
  import eval_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = DW_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  evalstack_arbiter_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

  state_e               r_state, w_state_d;
  logic                 r_owner, r_last_grant;
  logic [DEPTH_W-1:0]   r_depth, w_depth_eff;
  logic                 r_trig, r_push, r_err_ovf, r_err_unf;
  logic [DW-1:0]        r_wr;
  logic [1:0][DW-1:0]   r_read;
  logic [1:0]           r_done;

  slot_t      w_pend0, w_pend1, w_sel;
  logic [1:0] w_lock, w_own, w_elig, w_req, w_clear;
  logic       w_done_now, w_last_eff, w_win, w_rej_ovf, w_rej_unf, w_reject, w_issue;

  eval_req_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_trigger (bus.r0_trigger),
    .i_push    (bus.r0_push),
    .i_data    (bus.r0_write),
    .i_clear   (w_clear[0]),
    .o_pend    (w_pend0)
  );

  eval_req_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_trigger (bus.r1_trigger),
    .i_push    (bus.r1_push),
    .i_data    (bus.r1_write),
    .i_clear   (w_clear[1]),
    .o_pend    (w_pend1)
  );

  assign w_lock = {bus.r1_lock, bus.r0_lock};
  assign w_own  = r_owner ? 2'b10 : 2'b01;

  // Arbitration: on evaldone the next op is chosen against the post-completion depth
  always_comb begin
    w_done_now  = (r_state == BUSY) && bus.evaldone;
    w_last_eff  = w_done_now ? r_owner : r_last_grant;
    w_depth_eff = r_depth;
    if (w_done_now) begin
      w_depth_eff = r_push ? r_depth + DEPTH_W'(1) : r_depth - DEPTH_W'(1);
    end
    case (r_state)
      IDLE:    w_elig = 2'b11;
      LOCKED:  w_elig = w_lock[r_owner] ? w_own : 2'b11;
      // Owner's slot is retiring now, so only the other requester can follow
      BUSY:    w_elig = (bus.evaldone && !w_lock[r_owner]) ? ~w_own : 2'b00;
      default: w_elig = 2'b00;
    endcase
    w_req     = w_elig & {w_pend1.valid, w_pend0.valid};
    w_win     = (w_req == 2'b11) ? ~w_last_eff : w_req[1];
    w_sel     = w_win ? w_pend1 : w_pend0;
    w_rej_ovf = (|w_req) && w_sel.push && (w_depth_eff == FULL);
    w_rej_unf = (|w_req) && !w_sel.push && (w_depth_eff == '0);
    w_reject  = w_rej_ovf || w_rej_unf;
    w_issue   = (|w_req) && !w_reject;
    w_clear[0] = (w_done_now && !r_owner) || (w_reject && !w_win);
    w_clear[1] = (w_done_now && r_owner) || (w_reject && w_win);
  end

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      BUSY:    if (bus.evaldone) w_state_d = w_lock[r_owner] ? LOCKED : IDLE;
      LOCKED:  if (!w_lock[r_owner]) w_state_d = IDLE;
      default: ;
    endcase
    if (w_issue) begin
      w_state_d = BUSY;
    end else if (w_reject) begin
      w_state_d = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Datapath: stack strobe, completion, depth tracking and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_depth      <= '0;
      r_trig       <= 1'b0;
      r_push       <= 1'b0;
      r_wr         <= '0;
      r_read       <= '0;
      r_done       <= 2'b00;
      r_err_ovf    <= 1'b0;
      r_err_unf    <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      r_done <= 2'b00;
      if (w_done_now) begin
        r_depth          <= w_depth_eff;
        r_last_grant     <= r_owner;
        r_done[r_owner]  <= 1'b1;
        if (!r_push) r_read[r_owner] <= bus.evalread;
      end
      if (w_issue) begin
        r_trig  <= 1'b1;
        r_push  <= w_sel.push;
        r_wr    <= w_sel.data;
        r_owner <= w_win;
      end
      if (w_reject) begin
        if (w_rej_ovf) r_err_ovf <= 1'b1;
        if (w_rej_unf) r_err_unf <= 1'b1;
        r_done[w_win] <= 1'b1;
        r_read[w_win] <= '0;
      end
    end
  end

  assign bus.evaltrigger = r_trig;
  assign bus.evalpush    = r_push;
  assign bus.evalwrite   = r_wr;
  assign bus.r0_read     = r_read[0];
  assign bus.r1_read     = r_read[1];
  assign bus.r0_done     = r_done[0];
  assign bus.r1_done     = r_done[1];
  assign bus.depth       = r_depth;
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_unf     = r_err_unf;

endmodule

// File: tb/tb_evalstack_arbiter.sv
// Directed bench for evalstack_arbiter with a small two-cycle stack model.
module tb_evalstack_arbiter;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  evalstack_arbiter_if #(.DW(32), .DEPTH(DEPTH)) bus ();

  evalstack_arbiter #(.DEPTH(DEPTH), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stack model: evaldone two cycles after the evaltrigger cycle
  logic        m_cnt, m_push, m_done, inj_done;
  logic [31:0] m_data, m_rd, inj_rd;
  logic [31:0] mem [16];
  logic [3:0]  m_sp;

  assign bus.evaldone = m_done | inj_done;
  assign bus.evalread = inj_done ? inj_rd : m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 1'b0; m_push <= 1'b0; m_data <= '0; m_done <= 1'b0; m_rd <= '0; m_sp <= '0;
    end else begin
      m_done <= 1'b0;
      m_rd   <= '0;
      if (bus.evaltrigger) begin
        m_cnt <= 1'b1; m_push <= bus.evalpush; m_data <= bus.evalwrite;
      end else if (m_cnt) begin
        m_cnt  <= 1'b0;
        m_done <= 1'b1;
        if (m_push) m_sp <= m_sp + 4'd1;
        else begin m_rd <= mem[m_sp - 4'd1]; m_sp <= m_sp - 4'd1; end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && !bus.evaltrigger && m_cnt && m_push) mem[m_sp] <= m_data;
  end

  int total = 0;
  int bad = 0;
  int n_trig = 0, n_d0 = 0, n_d1 = 0;
  logic [31:0] last_wr = '0;

  typedef struct {
    int          who;
    bit          push;
    logic [31:0] data;
    int          trig;
    logic [31:0] rd;
    int          dep;
    bit          unf;
    bit          ovf;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (bus.evaltrigger) begin n_trig++; last_wr = bus.evalwrite; end
    if (bus.r0_done) n_d0++;
    if (bus.r1_done) n_d1++;
  endtask

  task automatic idle_inputs();
    bus.r0_trigger = 0; bus.r0_push = 0; bus.r0_write = '0; bus.r0_lock = 0;
    bus.r1_trigger = 0; bus.r1_push = 0; bus.r1_write = '0; bus.r1_lock = 0;
    inj_done = 0; inj_rd = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_r0_read"}, bus.r0_read, 0);
    chk({tag, "_r1_read"}, bus.r1_read, 0);
    chk({tag, "_strobes"}, {bus.r0_done, bus.r1_done, bus.evaltrigger, bus.evalpush,
                            bus.err_ovf, bus.err_unf}, 0);
    chk({tag, "_evalwrite"}, bus.evalwrite, 0);
    chk({tag, "_depth"}, 32'(bus.depth), 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
    n_trig = 0; n_d0 = 0; n_d1 = 0;
  endtask

  // Pulse one requester's trigger for the current cycle
  task automatic trig(input int who, input bit push, input logic [31:0] data);
    if (who == 0) begin bus.r0_trigger = 1; bus.r0_push = push; bus.r0_write = data; end
    else          begin bus.r1_trigger = 1; bus.r1_push = push; bus.r1_write = data; end
    cyc();
    bus.r0_trigger = 0; bus.r1_trigger = 0;
  endtask

  task automatic wait_done(input int who, input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (((who == 0) ? n_d0 : n_d1) >= target) begin ok = 1; break; end
      cyc();
    end
    if (!ok && (((who == 0) ? n_d0 : n_d1) >= target)) ok = 1;
    if (!ok) chk($sformatf("timeout_r%0d_done", who), 0, 1);
  endtask

  initial begin
    bit ok;
    int t0, d0, d1, first;
    logic [31:0] rd0, rd1;

    tbl[0]  = '{0, 1, 32'h11, 1, 32'h0,  1, 0, 0};
    tbl[1]  = '{1, 1, 32'h22, 1, 32'h0,  2, 0, 0};
    tbl[2]  = '{0, 0, 32'h0,  1, 32'h22, 1, 0, 0};
    tbl[3]  = '{1, 0, 32'h0,  1, 32'h11, 0, 0, 0};
    tbl[4]  = '{0, 0, 32'h0,  0, 32'h0,  0, 1, 0};  // underflow
    tbl[5]  = '{1, 1, 32'h33, 1, 32'h11, 1, 1, 0};
    tbl[6]  = '{1, 1, 32'h44, 1, 32'h11, 2, 1, 0};
    tbl[7]  = '{0, 1, 32'h55, 1, 32'h0,  3, 1, 0};
    tbl[8]  = '{0, 1, 32'h66, 1, 32'h0,  4, 1, 0};
    tbl[9]  = '{1, 1, 32'h77, 0, 32'h0,  4, 1, 1};  // overflow
    tbl[10] = '{0, 0, 32'h0,  1, 32'h66, 3, 1, 1};
    tbl[11] = '{1, 0, 32'h0,  1, 32'h55, 2, 1, 1};
    tbl[12] = '{0, 0, 32'h0,  1, 32'h44, 1, 1, 1};
    tbl[13] = '{1, 0, 32'h0,  1, 32'h33, 0, 1, 1};

    do_reset();
    chk_zero("reset");

    // Single push latency
    trig(0, 1, 32'hDEAD_BEEF);
    chk("push_trig_t1", bus.evaltrigger, 1);
    chk("push_dir_t1", bus.evalpush, 1);
    chk("push_data_t1", bus.evalwrite, 32'hDEAD_BEEF);
    cyc();
    chk("push_trig_t2", bus.evaltrigger, 0);
    cyc();
    chk("push_evaldone_t3", bus.evaldone, 1);
    chk("push_r0_done_t3", bus.r0_done, 0);
    cyc();
    chk("push_r0_done_t4", bus.r0_done, 1);
    chk("push_depth_t4", 32'(bus.depth), 1);

    // Contention: r1 loads [5,7] so last_grant stays 1, then both pop together
    do_reset();
    trig(1, 1, 32'd5); wait_done(1, 1, ok);
    trig(1, 1, 32'd7); wait_done(1, 2, ok);
    t0 = n_trig; d0 = n_d0; d1 = n_d1; first = -1; rd0 = '1; rd1 = '1;
    bus.r0_trigger = 1; bus.r0_push = 0; bus.r1_trigger = 1; bus.r1_push = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      bus.r0_trigger = 0; bus.r1_trigger = 0;
      if (bus.r0_done) begin rd0 = bus.r0_read; if (first < 0) first = 0; end
      if (bus.r1_done) begin rd1 = bus.r1_read; if (first < 0) first = 1; end
    end
    chk("cont_first", first, 0);
    chk("cont_r0_read", rd0, 7);
    chk("cont_r1_read", rd1, 5);
    chk("cont_depth", 32'(bus.depth), 0);
    chk("cont_trig_cnt", n_trig - t0, 2);
    chk("cont_done_cnt", (n_d0 - d0) + (n_d1 - d1), 2);

    // Lock burst: r1 holds the grant for three pushes while r0 waits with a push
    t0 = n_trig; d0 = n_d0; d1 = n_d1;
    bus.r1_lock = 1;
    trig(1, 1, 32'h101);
    trig(0, 1, 32'hAA);
    for (int k = 2; k <= 3; k++) begin
      wait_done(1, d1 + k - 1, ok);
      trig(1, 1, 32'h100 + k);
    end
    wait_done(1, d1 + 3, ok);
    cyc(); cyc(); cyc();
    chk("lock_r1_trigs", n_trig - t0, 3);
    chk("lock_last_wr", last_wr, 32'h103);
    chk("lock_r0_waits", n_d0 - d0, 0);
    bus.r1_lock = 0;
    chk("lock_drop_no_trig", bus.evaltrigger, 0);
    cyc();
    chk("lock_r0_issue", bus.evaltrigger, 1);
    chk("lock_r0_data", bus.evalwrite, 32'hAA);
    wait_done(0, d0 + 1, ok);
    chk("lock_depth", 32'(bus.depth), 4);

    // Table of single operations, including underflow and overflow
    do_reset();
    for (int i = 0; i < 14; i++) begin
      t0 = n_trig;
      d0 = (tbl[i].who == 0) ? n_d0 : n_d1;
      trig(tbl[i].who, tbl[i].push, tbl[i].data);
      wait_done(tbl[i].who, d0 + 1, ok);
      if (ok) begin
        chk($sformatf("v%0d_trig", i), n_trig - t0, tbl[i].trig);
        chk($sformatf("v%0d_read", i), (tbl[i].who == 0) ? bus.r0_read : bus.r1_read,
            tbl[i].rd);
        chk($sformatf("v%0d_depth", i), 32'(bus.depth), tbl[i].dep);
        chk($sformatf("v%0d_flags", i), {bus.err_unf, bus.err_ovf}, {tbl[i].unf, tbl[i].ovf});
      end
    end
    cyc(); cyc();
    chk("flags_sticky", {bus.err_unf, bus.err_ovf}, 2'b11);

    // Reset in the middle of an op, then a stray evaldone
    trig(0, 1, 32'h99);
    chk("midop_issue", bus.evaltrigger, 1);
    cyc();
    rst_n = 0;
    #1;
    chk_zero("midop_rst");
    cyc();
    rst_n = 1;
    cyc();
    d0 = n_d0; d1 = n_d1; t0 = n_trig;
    inj_done = 1; inj_rd = 32'h1234;
    cyc();
    inj_done = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("midop_no_done", (n_d0 - d0) + (n_d1 - d1), 0);
    chk("midop_no_trig", n_trig - t0, 0);
    chk_zero("midop_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evalstack_arbiter.md
Name: evalstack_arbiter

Overview:
- Shares the single evaluation-stack port (evalpush/evaltrigger/evalwrite/evalread/evaldone) between two requesters.
  - Requester 0: the instruction control sequencer.
  - Requester 1: the method-invoke/frame unit, which pops call arguments into a new local variable array.
- Captures single-cycle trigger pulses so that no request is lost while the stack is busy.
- Grants round-robin, with an optional lock for multi-operation bursts.
- Tracks stack depth and blocks overflow/underflow before it reaches the stack.

Parameters:
- DEPTH, 256, number of 32-bit entries in the evaluation stack.
- DW, 32, stack word width.

Ports:
- clk  in  1  clock (rising edge); single clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- r0_trigger  in  1  requester 0 single-cycle operation strobe.
- r0_push  in  1  requester 0: 1 = push, 0 = pop; sampled with r0_trigger.
- r0_write  in  DW  requester 0 push data; sampled with r0_trigger.
- r0_lock  in  1  requester 0 keeps the grant after its op completes, while held high.
- r0_read  out  DW  pop data returned to requester 0; registered.
- r0_done  out  1  single-cycle completion pulse to requester 0.
- r1_trigger, r1_push, r1_write, r1_lock, r1_read, r1_done  same as r0_*, for requester 1.
- evaltrigger  out  1  single-cycle strobe to the stack.
- evalpush  out  1  operation direction to the stack.
- evalwrite  out  DW  push data to the stack.
- evalread  in  DW  pop data from the stack; valid in the evaldone cycle.
- evaldone  in  1  single-cycle completion pulse from the stack.
- depth  out  $clog2(DEPTH+1)  current number of entries in the stack.
- err_ovf  out  1  sticky flag: a push was rejected because the stack was full.
- err_unf  out  1  sticky flag: a pop was rejected because the stack was empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0; depth is 0.
  - Pending slots are cleared; state goes to IDLE; last_grant is 1, so r0 wins the first tie.
  - Reset mid-operation abandons the in-flight op. No done pulse is ever issued for it, and a late evaldone after reset is ignored.
- Capture:
  - Each requester has one pending slot (valid, push, data), loaded on its trigger.
  - A trigger while that requester's own slot is already valid is a protocol violation. The new trigger is ignored and the slot is unchanged.
- States and transitions:
  - IDLE, with at least one slot valid, selects an owner:
    - If only one slot is valid, that requester wins.
    - If both are valid, the requester that is not last_grant wins.
  - The selected op is then checked against depth:
    - Push with depth==DEPTH: the op is rejected.
    - Pop with depth==0: the op is rejected.
  - Accepted op: in the same edge, evaltrigger, evalpush and evalwrite are driven from the slot, and state goes to BUSY.
    - evaltrigger is high for exactly one cycle.
  - Rejected op:
    - Set the matching sticky error flag.
    - Pulse rN_done next cycle with rN_read = 0.
    - Do not touch the stack; state goes to IDLE.
  - BUSY waits for evaldone. On evaldone:
    - rN_read is loaded with evalread (pop only; a push leaves rN_read unchanged).
    - rN_done pulses the following cycle.
    - The slot is cleared; last_grant is set to N.
    - depth changes by +1 on push, -1 on pop.
    - If rN_lock is high, go to LOCKED; otherwise go to IDLE.
  - LOCKED:
    - Only requester N's slot is served, using the same issue rules as IDLE.
    - When rN_lock falls, go to IDLE.
    - The other requester's slot stays pending.
- Latency:
  - From trigger at cycle T with the arbiter idle: evaltrigger at T+1.
  - From evaldone at cycle D: rN_done at D+1.
  - The earliest next issue is at D+1.
- Simultaneous events:
  - A trigger arriving in the same cycle as its own done is accepted into the freed slot.
  - Both triggers in one cycle are both captured; round-robin then orders them.
- evaldone outside BUSY is ignored and sets no flag.
- Error flags are cleared only by reset.

Decomposition:
- Shared package eval_pkg holds:
  - the state enum IDLE/BUSY/LOCKED;
  - the pending-slot struct {valid, push, data};
  - the DW default.
- One natural sub-module is eval_req_slot, the per-requester capture register. It is instantiated twice.

Test Plan:
- Single push: r0 triggers a push of 32'hDEAD_BEEF at T.
  - evaltrigger=1 and evalwrite=DEADBEEF at T+1.
  - Stack model replies evaldone at T+3; r0_done at T+4; depth=1.
- Contention: r0 and r1 trigger pops in the same cycle, with stack contents [5,7] (7 on top) and last_grant=1 after reset.
  - r0 is served first with r0_read=7, then r1 with r1_read=5.
  - depth=0; exactly two evaltrigger pulses.
- Lock burst: r1 holds r1_lock and issues 3 pushes back-to-back while r0 is pending with a push.
  - All three r1 pushes complete before r0 is issued.
  - r0 issues the cycle after r1_lock falls.
- Underflow: a pop at depth=0.
  - No evaltrigger; r0_done pulses with r0_read=0; err_unf=1 and it stays set.
- Overflow: with DEPTH=4, issue 5 pushes.
  - The fifth push is rejected, err_ovf=1, depth stays at 4.
- Reset mid-op: assert rst_n low while in BUSY, then drive evaldone after release.
  - No rN_done pulse; depth=0; all outputs are 0.
